// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
// Also used by the multicore interconnect.
package mem_port_arbiter_pkg;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INST  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_e;

    typedef enum logic {
        PORT_INST = 1'b0,
        PORT_DATA = 1'b1
    } arb_port_e;

    typedef struct packed {
        logic      valid;
        arb_port_e port;
    } arb_grant_t;

    // One memory-port transaction as presented to the single-ported memory
    typedef struct packed {
        logic              rd;
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic arb_port_e other_port(input arb_port_e p);
        return (p == PORT_INST) ? PORT_DATA : PORT_INST;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Combinational grant select between fetch and data requesters.
// Fixed data-first priority, or round-robin away from the last served port.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       inst_req,
    input  logic       data_req,
    input  arb_port_e  rr_last,
    input  logic       rr_mode,
    output arb_grant_t grant
);

    always_comb begin
        grant.valid = inst_req | data_req;
        grant.port  = PORT_DATA;
        if (inst_req && data_req) begin
            grant.port = rr_mode ? other_port(rr_last) : PORT_DATA;
        end else if (inst_req) begin
            grant.port = PORT_INST;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch and data requesters.
// One transaction at a time, registered memory strobes, optional wait timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              InstMem_Read,
    input  logic [ADDR_W-1:0] InstMem_Address,
    output logic              InstMem_Ready,
    output logic [DATA_W-1:0] InstMemData,
    input  logic              DataMem_Read,
    input  logic [BE_W-1:0]   DataMem_Write,
    input  logic [ADDR_W-1:0] DataMem_Address,
    input  logic [DATA_W-1:0] DataMem_In,
    output logic [DATA_W-1:0] DataMem_Out,
    output logic              DataMem_Ready,
    output logic              Mem_Read,
    output logic [BE_W-1:0]   Mem_Write,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [DATA_W-1:0] Mem_WrData,
    input  logic [DATA_W-1:0] Mem_RdData,
    input  logic              Mem_Ready,
    output logic              Arb_Timeout
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e        state;
    arb_port_e         rr_last;
    logic [CNT_W-1:0]  cnt;
    mem_req_t          mem_q;
    mem_req_t          inst_bus;
    mem_req_t          data_bus;
    arb_grant_t        grant;
    logic              inst_req;
    logic              data_req;
    logic              timeout_hit;
    logic              finish;
    logic [DATA_W-1:0] done_data;

    assign inst_req = InstMem_Read;
    assign data_req = DataMem_Read | (|DataMem_Write);

    arb_pick u_pick (
        .inst_req (inst_req),
        .data_req (data_req),
        .rr_last  (rr_last),
        .rr_mode  (PRIORITY_MODE != 0),
        .grant    (grant)
    );

    // Candidate memory transactions; a data write always wins over a data read
    always_comb begin
        inst_bus.rd    = 1'b1;
        inst_bus.be    = '0;
        inst_bus.addr  = InstMem_Address;
        inst_bus.wdata = mem_q.wdata;
        data_bus.rd    = ~(|DataMem_Write);
        data_bus.be    = DataMem_Write;
        data_bus.addr  = DataMem_Address;
        data_bus.wdata = DataMem_In;
    end

    // Memory completion wins over a timeout landing in the same cycle
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
    assign finish      = Mem_Ready | timeout_hit;
    assign done_data   = Mem_Ready ? Mem_RdData : '0;

    assign Mem_Read    = mem_q.rd;
    assign Mem_Write   = mem_q.be;
    assign Mem_Address = mem_q.addr;
    assign Mem_WrData  = mem_q.wdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_last       <= PORT_INST;
            cnt           <= '0;
            mem_q         <= '0;
            InstMem_Ready <= 1'b0;
            InstMemData   <= '0;
            DataMem_Ready <= 1'b0;
            DataMem_Out   <= '0;
            Arb_Timeout   <= 1'b0;
        end else begin
            InstMem_Ready <= 1'b0;
            DataMem_Ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant.valid) begin
                        cnt <= '0;
                        if (grant.port == PORT_DATA) begin
                            state <= ST_DATA;
                            mem_q <= data_bus;
                        end else begin
                            state <= ST_INST;
                            mem_q <= inst_bus;
                        end
                    end
                end
                ST_INST, ST_DATA: begin
                    if (finish) begin
                        state    <= ST_DRAIN;
                        cnt      <= '0;
                        mem_q.rd <= 1'b0;
                        mem_q.be <= '0;
                        if (!Mem_Ready) begin
                            Arb_Timeout <= 1'b1;
                        end
                        if (state == ST_INST) begin
                            rr_last       <= PORT_INST;
                            InstMem_Ready <= 1'b1;
                            InstMemData   <= done_data;
                        end else begin
                            rr_last       <= PORT_DATA;
                            DataMem_Ready <= 1'b1;
                            if (mem_q.rd) begin
                                DataMem_Out <= done_data;
                            end
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Wait out a level Mem_Ready so a new strobe never sees a stale completion
                    if (!Mem_Ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction bench for mem_port_arbiter, both priority modes.
// The expected grant order, timing and data come from a transaction-level model.
module tb_mem_port_arbiter;

    localparam int unsigned T = 8;

    typedef struct {
        bit          is_data;
        logic [29:0] addr;
        logic        rd;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
        int          hold;
        logic [31:0] rdata;
    } txn_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        sel;
    logic        rst_fx, rst_rr;
    logic        inst_rd;
    logic [29:0] inst_addr;
    logic        data_rd;
    logic [3:0]  data_be;
    logic [29:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    logic        fx_inst_ready, rr_inst_ready, o_inst_ready;
    logic [31:0] fx_inst_data,  rr_inst_data,  o_inst_data;
    logic [31:0] fx_data_out,   rr_data_out,   o_data_out;
    logic        fx_data_ready, rr_data_ready, o_data_ready;
    logic        fx_mem_read,   rr_mem_read,   o_mem_read;
    logic [3:0]  fx_mem_write,  rr_mem_write,  o_mem_write;
    logic [29:0] fx_mem_addr,   rr_mem_addr,   o_mem_addr;
    logic [31:0] fx_mem_wdata,  rr_mem_wdata,  o_mem_wdata;
    logic        fx_timeout,    rr_timeout,    o_timeout;

    int total = 0;
    int bad   = 0;
    int hold_rem = 0;

    // Reference model state
    bit          m_rr_last;
    bit          m_timeout;
    logic [31:0] m_inst_data;
    logic [31:0] m_data_out;

    always #5 clock = ~clock;

    // Only the selected DUT runs; the other is held in reset
    assign rst_fx = reset | sel;
    assign rst_rr = reset | ~sel;

    mem_port_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(T), .CNT_W(9)) dut_fx (
        .clock(clock), .reset(rst_fx),
        .InstMem_Read(inst_rd), .InstMem_Address(inst_addr),
        .InstMem_Ready(fx_inst_ready), .InstMemData(fx_inst_data),
        .DataMem_Read(data_rd), .DataMem_Write(data_be), .DataMem_Address(data_addr),
        .DataMem_In(data_in), .DataMem_Out(fx_data_out), .DataMem_Ready(fx_data_ready),
        .Mem_Read(fx_mem_read), .Mem_Write(fx_mem_write), .Mem_Address(fx_mem_addr),
        .Mem_WrData(fx_mem_wdata), .Mem_RdData(mem_rdata), .Mem_Ready(mem_ready),
        .Arb_Timeout(fx_timeout)
    );

    mem_port_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(T), .CNT_W(9)) dut_rr (
        .clock(clock), .reset(rst_rr),
        .InstMem_Read(inst_rd), .InstMem_Address(inst_addr),
        .InstMem_Ready(rr_inst_ready), .InstMemData(rr_inst_data),
        .DataMem_Read(data_rd), .DataMem_Write(data_be), .DataMem_Address(data_addr),
        .DataMem_In(data_in), .DataMem_Out(rr_data_out), .DataMem_Ready(rr_data_ready),
        .Mem_Read(rr_mem_read), .Mem_Write(rr_mem_write), .Mem_Address(rr_mem_addr),
        .Mem_WrData(rr_mem_wdata), .Mem_RdData(mem_rdata), .Mem_Ready(mem_ready),
        .Arb_Timeout(rr_timeout)
    );

    assign o_inst_ready = sel ? rr_inst_ready : fx_inst_ready;
    assign o_inst_data  = sel ? rr_inst_data  : fx_inst_data;
    assign o_data_out   = sel ? rr_data_out   : fx_data_out;
    assign o_data_ready = sel ? rr_data_ready : fx_data_ready;
    assign o_mem_read   = sel ? rr_mem_read   : fx_mem_read;
    assign o_mem_write  = sel ? rr_mem_write  : fx_mem_write;
    assign o_mem_addr   = sel ? rr_mem_addr   : fx_mem_addr;
    assign o_mem_wdata  = sel ? rr_mem_wdata  : fx_mem_wdata;
    assign o_timeout    = sel ? rr_timeout    : fx_timeout;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s (mode %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_rr_last   = 1'b0;
        m_timeout   = 1'b0;
        m_inst_data = '0;
        m_data_out  = '0;
        hold_rem    = 0;
        mem_ready   = 1'b0;
    endtask

    task automatic drive_hold();
        mem_ready = (hold_rem > 0);
        if (hold_rem > 0) hold_rem--;
    endtask

    function automatic txn_t mk(input bit is_data, input logic [29:0] addr, input logic rd,
                                input logic [3:0] be, input logic [31:0] wdata,
                                input int lat, input int hold, input logic [31:0] rdata);
        txn_t t;
        t.is_data = is_data; t.addr = addr; t.rd = rd; t.be = be;
        t.wdata = wdata; t.lat = lat; t.hold = hold; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t mk_rand(input bit is_data);
        txn_t t;
        int   op;
        t = mk(is_data, 30'($urandom), 1'b1, 4'h0, $urandom, $urandom_range(1, 10),
               $urandom_range(0, 3), $urandom);
        if (is_data) begin
            op = $urandom_range(0, 3);
            if (op >= 2) t.be = 4'($urandom_range(1, 15));
            if (op == 2) t.rd = 1'b0;
        end
        return t;
    endfunction

    // Wait for the grant, play memory for one transaction, check the completion
    task automatic serve(input txn_t t, input int exp_wait, output int next_wait);
        int          w;
        bit          seen;
        bit          timed;
        int          len;
        logic        exp_rd;
        logic [63:0] exp_strobe;
        w = 0;
        seen = 1'b0;
        next_wait = 2;
        while (!seen && w < 40) begin
            @(negedge clock);
            w++;
            if (o_mem_read || (o_mem_write != 4'h0)) seen = 1'b1;
            else begin
                drive_hold();
                check("gap_ready", {o_inst_ready, o_data_ready}, 2'b00);
            end
        end
        check("grant_delay", 64'(w), 64'(exp_wait));
        if (!seen) return;

        exp_rd     = (t.be == 4'h0);
        exp_strobe = {29'h0, exp_rd, t.be, t.addr};
        check("strobe", {29'h0, o_mem_read, o_mem_write, o_mem_addr}, exp_strobe);
        if (t.be != 4'h0) check("wrdata", 64'(o_mem_wdata), 64'(t.wdata));
        // The granted requester may change its address now; the latched one must hold
        if (t.is_data) data_addr = 30'($urandom);
        else           inst_addr = 30'($urandom);

        timed = (T != 0) && (t.lat > int'(T));
        len   = timed ? int'(T) : t.lat;
        for (int c = 1; c <= len; c++) begin
            if (c > 1) begin
                @(negedge clock);
                check("strobe_hold", {29'h0, o_mem_read, o_mem_write, o_mem_addr}, exp_strobe);
            end
            check("early_ready", {o_inst_ready, o_data_ready}, 2'b00);
            mem_ready = (c == t.lat);
            mem_rdata = (c == t.lat) ? t.rdata : $urandom;
        end

        @(negedge clock);
        m_rr_last = t.is_data;
        m_timeout = m_timeout | timed;
        if (!t.is_data) m_inst_data = timed ? 32'h0 : t.rdata;
        else if (t.be == 4'h0) m_data_out = timed ? 32'h0 : t.rdata;
        check("ready_pulse", {o_inst_ready, o_data_ready}, t.is_data ? 2'b01 : 2'b10);
        check("strobe_drop", {o_mem_read, o_mem_write}, 5'h0);
        check("inst_data", 64'(o_inst_data), 64'(m_inst_data));
        check("data_out", 64'(o_data_out), 64'(m_data_out));
        check("timeout_flag", 64'(o_timeout), 64'(m_timeout));

        if (t.is_data) begin data_rd = 1'b0; data_be = 4'h0; end
        else inst_rd = 1'b0;
        hold_rem  = timed ? 0 : t.hold;
        drive_hold();
        mem_rdata = $urandom;
        next_wait = (timed ? 0 : t.hold) + 2;
    endtask

    task automatic run_trial(input txn_t ti, input txn_t td, input bit use_i, input bit use_d);
        txn_t order[$];
        int   wait_cyc;
        bit   data_first;
        order = {};
        if (use_i && use_d) begin
            data_first = (sel == 1'b0) || (m_rr_last == 1'b0);
            if (data_first) order = {td, ti};
            else            order = {ti, td};
        end else if (use_d) order = {td};
        else                order = {ti};

        inst_rd   = use_i;
        inst_addr = ti.addr;
        data_rd   = use_d && td.rd;
        data_be   = use_d ? td.be : 4'h0;
        data_addr = td.addr;
        data_in   = td.wdata;

        wait_cyc = 1;
        foreach (order[k]) serve(order[k], wait_cyc, wait_cyc);
        inst_rd = 1'b0; data_rd = 1'b0; data_be = 4'h0;
        repeat (wait_cyc) begin
            @(negedge clock);
            drive_hold();
            check("tail_idle", {o_mem_read, o_mem_write, o_inst_ready, o_data_ready}, 7'h0);
        end
    endtask

    // Reset in the middle of a data read: everything clears, no completion pulse
    task automatic reset_mid_txn();
        data_rd = 1'b1; data_be = 4'h0; data_addr = 30'h123; mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_strobe", 64'(o_mem_read), 64'd1);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("rst_ctl", {o_inst_ready, o_data_ready, o_mem_read, o_mem_write, o_timeout}, 8'h0);
            check("rst_data", {o_inst_data, o_data_out}, 64'h0);
            check("rst_bus", {2'b0, o_mem_addr, o_mem_wdata}, 64'h0);
        end
        data_rd = 1'b0;
        reset   = 1'b0;
        model_reset();
        @(negedge clock);
        check("post_rst_ctl", {o_inst_ready, o_data_ready, o_mem_read, o_mem_write, o_timeout}, 8'h0);
        @(negedge clock);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int r;
        reset = 1'b1; sel = 1'b0;
        inst_rd = 1'b0; inst_addr = '0; data_rd = 1'b0; data_be = '0;
        data_addr = '0; data_in = '0; mem_rdata = '0; mem_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_ctl", {o_inst_ready, o_data_ready, o_mem_read, o_mem_write, o_timeout}, 8'h0);
        check("reset_data", {o_inst_data, o_data_out}, 64'h0);
        reset = 1'b0;

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            model_reset();
            @(negedge clock);
            // Single fetch, memory answers on the fifth strobe cycle
            run_trial(mk(0, 30'h10, 1, 4'h0, 32'h0, 5, 0, 32'h5), mk(1, 30'h0, 1, 4'h0, 32'h0, 1, 0, 32'h0), 1, 0);
            // Partial write leaves DataMem_Out alone
            run_trial(mk(0, 30'h0, 1, 4'h0, 32'h0, 1, 0, 32'h0),
                      mk(1, 30'h44, 0, 4'b0011, 32'hCAFE_F00D, 2, 0, 32'hDEAD_BEEF), 0, 1);
            // Both at once; mode 1 follows the data write above, so INST goes first
            run_trial(mk(0, 30'h20, 1, 4'h0, 32'h0, 1, 0, 32'h1111_2222),
                      mk(1, 30'h30, 1, 4'h0, 32'h0, 1, 0, 32'h3333_4444), 1, 1);
            // Long Mem_Ready hold keeps the pending request waiting in drain
            run_trial(mk(0, 30'h21, 1, 4'h0, 32'h0, 1, 4, 32'h5555_6666),
                      mk(1, 30'h31, 1, 4'h0, 32'h0, 1, 4, 32'h7777_8888), 1, 1);
            // Ready exactly on the last allowed cycle, then a true timeout
            run_trial(mk(0, 30'h22, 1, 4'h0, 32'h0, T, 0, 32'h9999_AAAA),
                      mk(1, 30'h32, 1, 4'h0, 32'h0, 20, 0, 32'hBBBB_CCCC), 1, 1);
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(1, 3);
                run_trial(mk_rand(0), mk_rand(1), r[0], r[1]);
            end
            reset_mid_txn();
            // rr_last is back to INST after reset
            run_trial(mk(0, 30'h25, 1, 4'h0, 32'h0, 2, 1, 32'h0102_0304),
                      mk(1, 30'h35, 1, 4'h0, 32'h0, 3, 0, 32'h0506_0708), 1, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
